// File: rtl/lsu_pkg.sv
// lsu_pkg: shared codes for the load/store initiator.
//   - request size codes, data_mem write/read control codes
//   - FSM state enum
//   - is_aligned(): natural-alignment test for a size/low-address pair
package lsu_pkg;

   localparam logic [1:0] SZ_B   = 2'd0;
   localparam logic [1:0] SZ_H   = 2'd1;
   localparam logic [1:0] SZ_W   = 2'd2;
   localparam logic [1:0] SZ_ILL = 2'd3;

   localparam logic [1:0] WE_NONE = 2'b00;
   localparam logic [1:0] WE_W    = 2'b01;
   localparam logic [1:0] WE_H    = 2'b10;
   localparam logic [1:0] WE_B    = 2'b11;

   localparam logic [2:0] RD_NONE = 3'd0;
   localparam logic [2:0] RD_LW   = 3'd1;
   localparam logic [2:0] RD_LHU  = 3'd2;
   localparam logic [2:0] RD_LH   = 3'd3;
   localparam logic [2:0] RD_LBU  = 3'd4;
   localparam logic [2:0] RD_LB   = 3'd5;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
      case (size)
         SZ_B:    is_aligned = 1'b1;
         SZ_H:    is_aligned = ~a[0];
         SZ_W:    is_aligned = (a == 2'b00);
         default: is_aligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_initiator_assemble.sv
// lsu_load_assemble: combinational load-data path.
//   data_q   : current assembly register
//   lane     : byte lane written by the current split beat
//   byte_in  : byte returned by a split (lbu) beat
//   word_in  : full mem_spo for an aligned access (already extended by memory)
//   aligned/size/sgn : latched request attributes
//   data_ins : next value of the assembly register
//   data_out : final, extended load result
module lsu_load_assemble
   import lsu_pkg::*;
(
   input  logic [31:0] data_q,
   input  logic [1:0]  lane,
   input  logic [7:0]  byte_in,
   input  logic [31:0] word_in,
   input  logic        aligned,
   input  logic [1:0]  size,
   input  logic        sgn,
   output logic [31:0] data_ins,
   output logic [31:0] data_out
);

   always_comb begin
      data_ins = data_q;
      if (aligned) begin
         data_ins = word_in;
      end else begin
         case (lane)
            2'd0: data_ins[7:0]   = byte_in;
            2'd1: data_ins[15:8]  = byte_in;
            2'd2: data_ins[23:16] = byte_in;
            default: data_ins[31:24] = byte_in;
         endcase
      end
   end

   // Split beats read zero-extended bytes, so only signed split halves need
   // extension; upper lanes of an unsigned split half stay cleared.
   always_comb begin
      data_out = data_q;
      if (!aligned && size == SZ_H && sgn)
         data_out = {{16{data_q[15]}}, data_q[15:0]};
   end

endmodule

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: MEM-stage load/store master for data_mem.
//   req_*  : valid/ready request from the pipeline (sampled only at accept)
//   resp_* : one-cycle response pulse with load data / error flag
//   mem_*  : data_mem port; all decoded from registered state, so they are
//            quiet outside ACCESS and drop immediately on reset
//   Misaligned half/word accesses are serialised into byte beats.
module lsu_mem_initiator
   import lsu_pkg::*;
#(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_wr,
   input  logic [1:0]    req_size,
   input  logic          req_signed,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          resp_valid,
   output logic [DW-1:0] resp_rdata,
   output logic          resp_err,
   output logic [AW-1:0] mem_a,
   output logic [DW-1:0] mem_d,
   output logic [1:0]    mem_we,
   output logic [2:0]    mem_rd_ctrl,
   input  logic [DW-1:0] mem_spo
);

   state_e        state_q, state_d;
   logic [1:0]    k_q, k_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [1:0]    size_q, size_d;
   logic          sgn_q, sgn_d;
   logic          wr_q, wr_d;
   logic          err_q, err_d;
   logic          aligned_q, aligned_d;
   logic [DW-1:0] data_q, data_d;

   logic [DW-1:0] data_ins, data_out;
   logic          last_beat;
   logic [7:0]    wbyte;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         k_q       <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         size_q    <= '0;
         sgn_q     <= 1'b0;
         wr_q      <= 1'b0;
         err_q     <= 1'b0;
         aligned_q <= 1'b0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         size_q    <= size_d;
         sgn_q     <= sgn_d;
         wr_q      <= wr_d;
         err_q     <= err_d;
         aligned_q <= aligned_d;
         data_q    <= data_d;
      end
   end

   lsu_load_assemble u_asm (
      .data_q   (data_q),
      .lane     (k_q),
      .byte_in  (mem_spo[7:0]),
      .word_in  (mem_spo),
      .aligned  (aligned_q),
      .size     (size_q),
      .sgn      (sgn_q),
      .data_ins (data_ins),
      .data_out (data_out)
   );

   assign last_beat = aligned_q || (size_q == SZ_H ? (k_q == 2'd1) : (k_q == 2'd3));

   always_comb begin
      case (k_q)
         2'd0:    wbyte = wdata_q[7:0];
         2'd1:    wbyte = wdata_q[15:8];
         2'd2:    wbyte = wdata_q[23:16];
         default: wbyte = wdata_q[31:24];
      endcase
   end

   // Next state
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      size_d    = size_q;
      sgn_d     = sgn_q;
      wr_d      = wr_q;
      err_d     = err_q;
      aligned_d = aligned_q;
      data_d    = data_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d    = req_addr;
               wdata_d   = req_wdata;
               size_d    = req_size;
               sgn_d     = req_signed;
               wr_d      = req_wr;
               k_d       = '0;
               data_d    = '0;
               err_d     = (req_size == SZ_ILL);
               aligned_d = is_aligned(req_size, req_addr[1:0]);
               state_d   = (req_size == SZ_ILL) ? DONE : ACCESS;
            end
         end
         ACCESS: begin
            if (!wr_q) data_d = data_ins;
            if (last_beat) state_d = DONE;
            else           k_d = k_q + 2'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      req_ready   = (state_q == IDLE);
      resp_valid  = (state_q == DONE);
      resp_err    = (state_q == DONE) && err_q;
      resp_rdata  = (state_q == DONE && !wr_q && !err_q) ? data_out : '0;
      mem_a       = '0;
      mem_d       = '0;
      mem_we      = WE_NONE;
      mem_rd_ctrl = RD_NONE;
      if (state_q == ACCESS) begin
         // k stays 0 for aligned accesses, so this covers both cases
         mem_a = addr_q + AW'(k_q);
         if (wr_q) begin
            if (aligned_q) begin
               mem_d = wdata_q;
               case (size_q)
                  SZ_B:    mem_we = WE_B;
                  SZ_H:    mem_we = WE_H;
                  default: mem_we = WE_W;
               endcase
            end else begin
               mem_d  = {24'd0, wbyte};
               mem_we = WE_B;
            end
         end else begin
            if (aligned_q) begin
               case (size_q)
                  SZ_B:    mem_rd_ctrl = sgn_q ? RD_LB : RD_LBU;
                  SZ_H:    mem_rd_ctrl = sgn_q ? RD_LH : RD_LHU;
                  default: mem_rd_ctrl = RD_LW;
               endcase
            end else begin
               mem_rd_ctrl = RD_LBU;
            end
         end
      end
   end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator: the CPU-side master that drives the data-memory port (byte address, write data, write-control code, read-control code) and consumes its combinational read data.
- Accepts one load/store request at a time from the MEM stage via a valid/ready handshake.
- Naturally aligned accesses complete in a single memory cycle.
- Misaligned halfword/word accesses are split into sequential byte accesses; the block assembles, sign-extends and returns the result.
- Sits between the pipeline MEM stage and data_mem.

Parameters:
- AW, 10, byte-address width of the memory port; all address arithmetic wraps modulo 2^AW.
- DW, 32, data width; fixed at 32.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  asynchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_signed  in  1  sign-extend load result (byte/half only).
- req_addr  in  AW  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse; load data / store completion.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; illegal size.
- mem_a  out  AW  memory byte address.
- mem_d  out  32  memory write data.
- mem_we  out  2  00 none, 01 word, 10 half, 11 byte.
- mem_rd_ctrl  out  3  0 none, 1 lw, 2 lhu, 3 lh, 4 lbu, 5 lb.
- mem_spo  in  32  memory read data, combinational from mem_a/mem_rd_ctrl.

Behaviour:
- Reset values: state IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_we = 00, mem_rd_ctrl = 0, mem_a = 0, mem_d = 0.
- All mem_* outputs decode combinationally from registered state, so reset forces mem_we = 00 immediately.
- States:
  - IDLE: on req_valid & req_ready, latch the request, set beat counter k = 0 and go to ACCESS. If size == 3, go straight to DONE with err = 1 and issue no memory access.
  - ACCESS, aligned request (byte; half with addr[0] = 0; word with addr[1:0] = 0): one beat.
    - mem_a = addr.
    - Loads: rd_ctrl = lb/lbu/lh/lhu/lw per size and signed.
    - Stores: we = 11/10/01 per size, mem_d = wdata.
    - mem_spo is captured at the edge; next state DONE.
  - ACCESS, split request: N beats, N = 2 (half) or 4 (word).
    - Beat k: mem_a = (addr + k) mod 2^AW.
    - Loads: rd_ctrl = lbu; capture mem_spo[7:0] into byte lane k.
    - Stores: we = 11, mem_d[7:0] = wdata[8k+7:8k], upper bits 0.
    - k increments each cycle; after beat N-1, go to DONE.
  - DONE: resp_valid = 1 for exactly one cycle, resp_rdata = assembled data, then IDLE.
    - Split signed half loads are sign-extended from bit 15.
    - Stores return rdata = 0.
- Latency from the accept edge to resp_valid: aligned 2 cycles; split half 3; split word 5; illegal size 1.
- Throughput: the next accept is possible in the cycle after DONE.
- Outside ACCESS, mem_we = 00 and mem_rd_ctrl = 0: no spurious reads or writes.
- Request fields are sampled only at accept; changes afterwards are ignored.
- Address wrap: beats crossing 0x3FF wrap to 0x000.
- Asynchronous reset mid-split:
  - Remaining beats are abandoned and no resp_valid is issued.
  - Bytes already written stay written.
  - req_ready = 1 after release.

Decomposition:
- Package lsu_pkg holds:
  - size codes, mem_we codes, mem_rd_ctrl codes;
  - state enum {IDLE, ACCESS, DONE};
  - function is_aligned(size, addr[1:0]).
- One sub-module, lsu_load_assemble (combinational): byte-lane insert, final merge and sign/zero extension.

Test Plan:
1. Aligned lw at 0x008, mem word2 = 0xDEADBEEF -> one ACCESS beat with mem_a = 0x008, rd_ctrl = 1; resp_valid at accept+2; rdata = 0xDEADBEEF.
2. Misaligned lw at 0x00B, word2 = 0x44332211, word3 = 0x88776655 -> four lbu beats at 0x00B/0x00C/0x00D/0x00E; resp at accept+5; rdata = 0x77665544.
3. Misaligned signed lh at 0x003, word0 byte3 = 0xF0, word1 byte0 = 0x9A -> two beats; rdata = 0xFFFF9AF0. The same access unsigned -> rdata = 0x00009AF0.
4. Misaligned sw at 0x001, data 0xA1B2C3D4, words 0/1 = 0 -> four we = 11 beats with mem_d = 0xD4, 0xC3, 0xB2, 0xA1; afterwards word0 = 0xB2C3D400, word1 = 0x000000A1; resp rdata = 0.
5. Wrap and illegal size:
   - lhu at 0x3FF with byte 0x3FF = 0x12, byte 0x000 = 0x34 -> beats at 0x3FF then 0x000; rdata = 0x00003412.
   - req_size = 3 -> no mem activity; resp_err = 1 at accept+1.
6. rstn low during beat 2 of the test-4 store -> mem_we = 00 immediately; only bytes 0x001 and 0x002 written; no resp_valid; after release req_ready = 1 and an aligned sb at 0x010 completes normally.
